// File: rtl/km_modexp_seq.sv
// Sequential modular exponentiation (right-to-left square-and-multiply) around
// the combinational semi-Karatsuba multiplier km_b; result = base^exp mod Q.

module km_b #(
    parameter int v  = 16,
    parameter int v1 = 13,
    parameter int v2 = 11
) (
    input  logic [2*v-1:0] a,
    input  logic [2*v-1:0] b,
    output logic [2*v-1:0] p
);
    localparam int W  = 2 * v;
    localparam int TW = W + 16;
    localparam int ZW = 2 * v + 2;
    localparam logic [63:0]  Q64 = (64'd1 << W) - (64'd1 << v1) - (64'd1 << v2) + 64'd1;
    localparam logic [W+1:0] Q_T = Q64[W+1:0];

    logic [v-1:0]    a_hi, a_lo, b_hi, b_lo;
    logic [v:0]      sa, sb;
    logic [W-1:0]    z2, z0;
    logic [ZW-1:0]   z1m, z1;
    logic [2*W-1:0]  prod;
    logic [W-1:0]    h, l;
    logic [TW-1:0]   t1;
    logic [TW-W-1:0] h2;
    logic [W-1:0]    l2;
    logic [W+1:0]    t2;

    always_comb begin
        a_hi = a[W-1:v];
        a_lo = a[v-1:0];
        b_hi = b[W-1:v];
        b_lo = b[v-1:0];
        z2   = W'(a_hi) * W'(b_hi);
        z0   = W'(a_lo) * W'(b_lo);
        sa   = {1'b0, a_hi} + {1'b0, a_lo};
        sb   = {1'b0, b_hi} + {1'b0, b_lo};
        z1m  = ZW'(sa) * ZW'(sb);
        z1   = z1m - ZW'(z2) - ZW'(z0);
        prod = {z2, z0} + ((2*W)'(z1) << v);
        // 2^W == 2^v1 + 2^v2 - 1 (mod Q): fold the high word down twice
        h    = prod[2*W-1:W];
        l    = prod[W-1:0];
        t1   = (TW'(h) << v1) + (TW'(h) << v2) + TW'(l) - TW'(h);
        h2   = t1[TW-1:W];
        l2   = t1[W-1:0];
        t2   = ((W+2)'(h2) << v1) + ((W+2)'(h2) << v2) + (W+2)'(l2) - (W+2)'(h2);
        p    = (t2 >= Q_T) ? W'(t2 - Q_T) : W'(t2);
    end
endmodule

// state | meaning
// IDLE  | waiting for start
// LOAD  | reduce base into b_reg, acc = 1
// MUL   | acc *= b_reg when current exponent bit is set
// SQR   | b_reg = b_reg^2, shift exponent, count bit
// DONE  | publish result, pulse done
module km_modexp_seq #(
    parameter int          W  = 32,
    parameter int          EW = 32,
    parameter logic [W-1:0] Q = 32'd4294957057
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  base,
    input  logic [EW-1:0] exp,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result
);
    localparam int CW = $clog2(EW) + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_SQR, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   base_q, base_d;
    logic [EW-1:0]  exp_q, exp_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   b_reg_q, b_reg_d;
    logic [EW-1:0]  e_reg_q, e_reg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   result_q, result_d;
    logic           done_q, done_d;
    logic [W-1:0]   mul_a, mul_b, mul_p;

    assign mul_a = (state_q == S_SQR) ? b_reg_q : acc_q;
    assign mul_b = b_reg_q;

    km_b #(.v(W/2), .v1(13), .v2(11)) u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        exp_d    = exp_q;
        acc_d    = acc_q;
        b_reg_d  = b_reg_q;
        e_reg_d  = e_reg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base;
                    exp_d   = exp;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // 2^W < 2Q, so a single conditional subtract fully reduces base
                b_reg_d = (base_q >= Q) ? base_q - Q : base_q;
                acc_d   = W'(1);
                e_reg_d = exp_q;
                cnt_d   = '0;
                state_d = S_MUL;
            end
            S_MUL: begin
                if (e_reg_q[0]) acc_d = mul_p;
                state_d = S_SQR;
            end
            S_SQR: begin
                b_reg_d = mul_p;
                e_reg_d = e_reg_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(EW - 1)) begin
                    state_d  = S_DONE;
                    result_d = acc_q;
                    done_d   = 1'b1;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            exp_q    <= '0;
            acc_q    <= '0;
            b_reg_q  <= '0;
            e_reg_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            acc_q    <= acc_d;
            b_reg_q  <= b_reg_d;
            e_reg_q  <= e_reg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign result = result_q;
endmodule

// File: tb/tb_km_modexp_seq.sv
// Directed and random checks of km_modexp_seq against a plain 64-bit
// modular-power reference, including latency, busy framing and async reset.

module tb_km_modexp_seq;
    localparam logic [31:0] Q = 32'd4294957057;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base;
    logic [31:0] exp_v;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_vec = 0;
    int n_bad = 0;

    km_modexp_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .base   (base),
        .exp    (exp_v),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_vec++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] ref_pow(input logic [31:0] b, input logic [31:0] e);
        logic [63:0] r, x;
        r = 64'd1;
        x = {32'd0, b} % {32'd0, Q};
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * x) % {32'd0, Q};
            x = (x * x) % {32'd0, Q};
        end
        return r[31:0];
    endfunction

    task automatic run_op(input logic [31:0] b, input logic [31:0] e, input logic [31:0] want,
                          input string tag, input bit noise);
        int n, nb;
        @(posedge clk); #1;
        base  = b;
        exp_v = e;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n  = 1;
        nb = 0;
        while (!done && n < 200) begin
            if (busy) nb++;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                base  = $urandom;
                exp_v = $urandom;
            end
            @(posedge clk); #1;
            n++;
        end
        if (busy) nb++;
        start = 1'b0;
        chk({tag, " latency"}, 64'(n), 64'd66);
        chk({tag, " result"}, {32'd0, result}, {32'd0, want});
        chk({tag, " busy cycles"}, 64'(nb), 64'd66);
        @(posedge clk); #1;
        chk({tag, " busy after"}, {63'd0, busy}, 64'd0);
        chk({tag, " done after"}, {63'd0, done}, 64'd0);
        chk({tag, " result held"}, {32'd0, result}, {32'd0, want});
    endtask

    initial begin
        int m;
        logic [31:0] rb, re;
        rst_n = 1'b0;
        start = 1'b0;
        base  = '0;
        exp_v = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset result", {32'd0, result}, 64'd0);
        rst_n = 1'b1;

        run_op(32'd3, 32'd5, 32'd243, "3^5", 1'b0);
        run_op(32'd2, 32'd32, 32'd10239, "2^32", 1'b0);
        run_op(Q - 32'd1, 32'd3, 32'd4294957056, "(Q-1)^3", 1'b0);
        run_op(Q - 32'd1, 32'd2, 32'd1, "(Q-1)^2", 1'b0);
        run_op(32'd0, 32'd0, 32'd1, "0^0", 1'b0);
        run_op(32'd0, 32'd7, 32'd0, "0^7", 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 32'd10238, "ffffffff^1", 1'b0);
        run_op(Q, 32'd5, 32'd0, "Q^5", 1'b0);
        run_op(32'd7, 32'd0, 32'd1, "7^0", 1'b0);
        run_op(32'd3, 32'd5, 32'd243, "noise 3^5", 1'b1);

        // start held high: back-to-back operations one IDLE cycle apart
        @(posedge clk); #1;
        base  = 32'd3;
        exp_v = 32'd5;
        start = 1'b1;
        m = 0;
        do begin @(posedge clk); #1; m++; end while (!done && m < 200);
        chk("b2b first latency", 64'(m), 64'd66);
        chk("b2b first result", {32'd0, result}, 64'd243);
        m = 0;
        do begin @(posedge clk); #1; m++; end while (!done && m < 200);
        chk("b2b done spacing", 64'(m), 64'd67);
        chk("b2b second result", {32'd0, result}, 64'd243);
        start = 1'b0;
        @(posedge clk); #1;
        chk("b2b idle busy", {63'd0, busy}, 64'd0);

        // async reset at cycle 30 of an operation
        base  = 32'd5;
        exp_v = 32'hFFFF_FFFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid reset busy", {63'd0, busy}, 64'd0);
        chk("mid reset done", {63'd0, done}, 64'd0);
        chk("mid reset result", {32'd0, result}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd3, 32'd5, 32'd243, "post reset 3^5", 1'b0);

        for (int i = 0; i < 1000; i++) begin
            rb = $urandom;
            re = (i % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            run_op(rb, re, ref_pow(rb, re), "random", 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
